// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   General-purpose register file: 2**ADDR_W registers of DATA_W bits with
//   register 0 hardwired to zero. It provides two combinational read ports
//   with write-before-read bypass and one synchronous write port. A debug read
//   port shows architectural state only, without bypass. A 16-bit counter
//   tracks committed writes.
//
// Ports
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous active-low reset (clears all state)
//   we       in   1       write enable
//   waddr    in   ADDR_W  write register index (destination select rt/rd)
//   wdata    in   DATA_W  write data (writeback select ALU/memory)
//   raddr1   in   ADDR_W  read port 1 index (rs)
//   raddr2   in   ADDR_W  read port 2 index (rt)
//   rdata1   out  DATA_W  read port 1 data (bypassed)
//   rdata2   out  DATA_W  read port 2 data (bypassed)
//   dbg_addr in   ADDR_W  debug read index
//   dbg_data out  DATA_W  debug read data (stored state only)
//   wr_count out  16      committed writes, excluding writes to register 0
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;
    logic              commit;

    // A write takes effect only when enabled and not aimed at register 0.
    assign commit     = we && (waddr != '0);
    assign wr_count_d = wr_count_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            wr_count_q <= '0;
        end else if (commit) begin
            regs_q[waddr] <= wdata;
            wr_count_q    <= wr_count_d;
        end
    end

    // Reads: index 0 forced to zero, then bypass the in-flight write so the
    // decode stage sees writeback data in the same cycle. Reset forces zero
    // on every read path, bypass included.
    always_comb begin
        rdata1   = '0;
        rdata2   = '0;
        dbg_data = '0;
        if (rst_n) begin
            if (raddr1 != '0) begin
                rdata1 = (commit && (waddr == raddr1)) ? wdata : regs_q[raddr1];
            end
            if (raddr2 != '0) begin
                rdata2 = (commit && (waddr == raddr2)) ? wdata : regs_q[raddr2];
            end
            if (dbg_addr != '0) begin
                dbg_data = regs_q[dbg_addr];
            end
        end
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0055;
        raddr1 = 5'd4; raddr2 = 5'd4; dbg_addr = 5'd4;
        #2;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2 got %h exp %h", rdata2, 32'h0); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got %h exp %h", dbg_data, 32'h0); end
        tick();
        checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wrcount got %h exp %h", wr_count, 16'h0); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_write_ignored got %h exp %h", rdata1, 32'h0); end
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_release_r4 got %h exp %h", dbg_data, 32'h0); end
    endtask

    task automatic test_write_read();
        tick();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; raddr1 = 5'd5; dbg_addr = 5'd5;
        #1;
        checks++; if (rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rdata1 got %h exp %h", rdata1, 32'hDEAD_BEEF); end
        checks++; if (dbg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_dbg got %h exp %h", dbg_data, 32'hDEAD_BEEF); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count1 got %h exp %h", wr_count, 16'd1); end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7;
        #1;
        checks++; if (rdata1 !== 32'h1234_5678) begin errors++; $display("FAIL byp_rdata1 got %h exp %h", rdata1, 32'h1234_5678); end
        checks++; if (rdata2 !== 32'h1234_5678) begin errors++; $display("FAIL byp_rdata2 got %h exp %h", rdata2, 32'h1234_5678); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL byp_dbg_before got %h exp %h", dbg_data, 32'h0); end
        tick();
        we = 1'b0;
        #1;
        checks++; if (dbg_data !== 32'h1234_5678) begin errors++; $display("FAIL byp_dbg_after got %h exp %h", dbg_data, 32'h1234_5678); end
        checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL byp_wrcount got %h exp %h", wr_count, 16'd2); end
        raddr1 = 5'd5; raddr2 = 5'd7;
        #1;
        checks++; if (rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL two_port_r5 got %h exp %h", rdata1, 32'hDEAD_BEEF); end
        checks++; if (rdata2 !== 32'h1234_5678) begin errors++; $display("FAIL two_port_r7 got %h exp %h", rdata2, 32'h1234_5678); end
    endtask

    task automatic test_r0();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; dbg_addr = 5'd0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_same got %h exp %h", rdata1, 32'h0); end
        tick();
        we = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL r0_next got %h exp %h", rdata1, 32'h0); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL r0_dbg got %h exp %h", dbg_data, 32'h0); end
        checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL r0_wrcount got %h exp %h", wr_count, 16'd2); end
    endtask

    task automatic test_we_low();
        we = 1'b0; waddr = 5'd5; wdata = 32'h0000_0001; dbg_addr = 5'd5;
        tick();
        checks++; if (dbg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL we_low_r5 got %h exp %h", dbg_data, 32'hDEAD_BEEF); end
        checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL we_low_wrcount got %h exp %h", wr_count, 16'd2); end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; waddr = 5'd9; wdata = 32'hA; raddr2 = 5'd9; dbg_addr = 5'd9;
        #1;
        checks++; if (rdata2 !== 32'hA) begin errors++; $display("FAIL b2b_first got %h exp %h", rdata2, 32'hA); end
        tick();
        wdata = 32'hB;
        #1;
        checks++; if (rdata2 !== 32'hB) begin errors++; $display("FAIL b2b_second got %h exp %h", rdata2, 32'hB); end
        checks++; if (dbg_data !== 32'hA) begin errors++; $display("FAIL b2b_dbg_mid got %h exp %h", dbg_data, 32'hA); end
        tick();
        we = 1'b0;
        #1;
        checks++; if (rdata2 !== 32'hB) begin errors++; $display("FAIL b2b_stored got %h exp %h", rdata2, 32'hB); end
        checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL b2b_wrcount got %h exp %h", wr_count, 16'd4); end
    endtask

    task automatic test_fill_reset();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i);
            tick();
        end
        we = 1'b0;
        dbg_addr = 5'd31; raddr1 = 5'd17; raddr2 = 5'd9;
        #1;
        checks++; if (dbg_data !== 32'd31) begin errors++; $display("FAIL fill_r31 got %h exp %h", dbg_data, 32'd31); end
        checks++; if (rdata1 !== 32'd17) begin errors++; $display("FAIL fill_r17 got %h exp %h", rdata1, 32'd17); end
        checks++; if (wr_count !== 16'd35) begin errors++; $display("FAIL fill_wrcount got %h exp %h", wr_count, 16'd35); end
        // Start a write, then assert reset in the same cycle; reset must win.
        we = 1'b1; waddr = 5'd12; wdata = 32'h55; raddr1 = 5'd12;
        #1;
        checks++; if (rdata1 !== 32'h55) begin errors++; $display("FAIL pre_reset_bypass got %h exp %h", rdata1, 32'h55); end
        rst_n = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL async_rdata1 got %h exp %h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL async_rdata2 got %h exp %h", rdata2, 32'h0); end
        checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL async_wrcount got %h exp %h", wr_count, 16'h0); end
        tick();
        rst_n = 1'b1; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL cleared_r%0d got %h exp %h", i, dbg_data, 32'h0); end
        end
        checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL midwrite_wrcount got %h exp %h", wr_count, 16'h0); end
        // First edge after release with we=1 is an ordinary write.
        we = 1'b1; waddr = 5'd12; wdata = 32'h77; dbg_addr = 5'd12;
        tick();
        we = 1'b0;
        #1;
        checks++; if (dbg_data !== 32'h77) begin errors++; $display("FAIL release_write got %h exp %h", dbg_data, 32'h77); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL release_wrcount got %h exp %h", wr_count, 16'd1); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL wrap_start got %h exp %h", wr_count, 16'h0); end
        we = 1'b1; waddr = 5'd3; dbg_addr = 5'd3;
        for (int i = 0; i < 65536; i++) begin
            wdata = 32'(i);
            tick();
        end
        we = 1'b0;
        #1;
        checks++; if (wr_count !== 16'h0000) begin errors++; $display("FAIL wrap_65536 got %h exp %h", wr_count, 16'h0000); end
        checks++; if (dbg_data !== 32'd65535) begin errors++; $display("FAIL wrap_r3 got %h exp %h", dbg_data, 32'd65535); end
        we = 1'b1; wdata = 32'h0000_CAFE;
        tick();
        we = 1'b0;
        #1;
        checks++; if (wr_count !== 16'h0001) begin errors++; $display("FAIL wrap_65537 got %h exp %h", wr_count, 16'h0001); end
        checks++; if (dbg_data !== 32'h0000_CAFE) begin errors++; $display("FAIL wrap_r3_last got %h exp %h", dbg_data, 32'h0000_CAFE); end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_we_low();
        test_back_to_back();
        test_fill_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DATA_W, default 32, width of each register and of all data ports.
REQ-002 Parameter: ADDR_W, default 5, register address width; register count is 2**ADDR_W (32).
REQ-003 Port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: we  input  1  write enable; 1 commits wdata to waddr at the next rising edge.
REQ-006 Port: waddr  input  ADDR_W  write register index; this is the output of the 5-bit destination select (rt/rd).
REQ-007 Port: wdata  input  DATA_W  write data; this is the output of the 32-bit writeback select (ALU/memory).
REQ-008 Port: raddr1  input  ADDR_W  read port 1 index (rs).
REQ-009 Port: raddr2  input  ADDR_W  read port 2 index (rt).
REQ-010 Port: rdata1  output  DATA_W  read port 1 data.
REQ-011 Port: rdata2  output  DATA_W  read port 2 data.
REQ-012 Port: dbg_addr  input  ADDR_W  debug/test read index.
REQ-013 Port: dbg_data  output  DATA_W  debug read data; no bypass (architectural state only).
REQ-014 Port: wr_count  output  16  count of committed writes, excluding writes to register 0.

Function
REQ-015 Storage: 2**ADDR_W registers of DATA_W bits each; register 0 is hardwired to 0.
REQ-016 Write: on the rising clk edge with we=1 and waddr!=0, reg[waddr] <= wdata; with we=0, no register changes.
REQ-017 Write to register 0: discarded, no state change, wr_count not incremented.
REQ-018 Read ports 1/2: combinational; rdataN = reg[raddrN] within the same cycle; zero clock latency.
REQ-019 Bypass: if we=1, waddr==raddrN and waddr!=0, rdataN = wdata in the same cycle (write-before-read), so the decode stage sees the value being written back.
REQ-020 raddrN==0: rdataN = 0 regardless of we/waddr/wdata.
REQ-021 Both read ports may address the same register, including the bypassed one; each independently obeys REQ-018 to REQ-020.
REQ-022 dbg_data = reg[dbg_addr], combinational, never bypassed; it shows the new value only from the cycle after the write edge.
REQ-023 wr_count increments by 1 on each edge that commits a write (REQ-016); it wraps 0xFFFF -> 0x0000 with no saturation or flag.
REQ-024 Repeated writes to one address on consecutive edges: each commits in order; the last written value persists.
REQ-025 No X propagation: all outputs are defined for any defined input combination; no latches are inferred.

Reset
REQ-026 rst_n=0 clears all registers and wr_count to 0 immediately, without waiting for clk.
REQ-027 While rst_n=0: writes are ignored, and rdata1, rdata2 and dbg_data read 0, bypass included.
REQ-028 Release: the first rising edge with rst_n=1 and we=1 is a normal write; rst_n deassertion is synchronized externally.
REQ-029 Reset asserted mid-write (same cycle as we=1): reset wins; the register stays 0 and wr_count stays 0.

Verification
REQ-030 Write 0xDEADBEEF to r5, next cycle raddr1=5 -> rdata1=0xDEADBEEF; dbg_addr=5 -> dbg_data=0xDEADBEEF; wr_count=1.
REQ-031 we=1, waddr=7, wdata=0x12345678 with raddr1=raddr2=7 in the same cycle -> both rdata=0x12345678 before the edge; dbg_data (addr 7) =0 before the edge and 0x12345678 after it.
REQ-032 Write 0xFFFFFFFF to r0, raddr1=0 in the same and the next cycle -> rdata1=0 both times; wr_count unchanged.
REQ-033 Fill r1..r31 with value=index, then assert rst_n=0 between clock edges -> all reads 0 immediately; wr_count=0.
REQ-034 Perform 65536 writes to r3 -> wr_count=0x0000; 65537th write -> 0x0001; r3 holds the last value.
REQ-035 Back-to-back writes to r9: 0xA, then 0xB, with raddr2=9 held -> rdata2 sequence 0xA (bypass), 0xB (bypass), then 0xB (stored).
